// File: rtl/packet_order_scheduler.sv
// Round-robin snoop dispatch and in-order forward grant for N BPF VMs.
// An order FIFO of VM indices makes packets leave in the order they arrived.
module packet_order_scheduler #(
  parameter int N     = 5,
  parameter int SEL_W = 3
) (
  input  logic             axi_aclk,
  input  logic             rst,
  input  logic             snooper_done,
  output logic             ready_for_snooper,
  input  logic [N-1:0]     vm_snoop_ready,
  output logic [N-1:0]     vm_snoop_grant,
  input  logic             forwarder_done,
  output logic             ready_for_forwarder,
  input  logic [N-1:0]     vm_fwd_ready,
  input  logic [N-1:0]     vm_reject,
  output logic [N-1:0]     vm_fwd_grant,
  output logic [SEL_W-1:0] fwd_sel,
  output logic [SEL_W:0]   order_count
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);
  localparam logic [SEL_W:0]   FULL = (SEL_W + 1)'(N);
  localparam logic [N-1:0]     ONE  = N'(1);

  typedef enum logic {S_IDLE, S_GRANT} s_state_t;
  typedef enum logic {F_IDLE, F_GRANT} f_state_t;

  s_state_t s_state, s_next;
  f_state_t f_state, f_next;

  logic [SEL_W-1:0] snoop_idx, snoop_idx_d;
  logic [SEL_W-1:0] rr_ptr, rr_d;
  logic [N-1:0]     snoop_grant_d, fwd_grant_d;
  logic [SEL_W-1:0] fwd_sel_d;
  logic [SEL_W-1:0] fifo_q [N];
  logic [SEL_W-1:0] rd_ptr, wr_ptr;
  logic [N-1:0]     reject_pend, reject_pend_d;

  logic             snoop_found;
  logic [SEL_W-1:0] snoop_pick;
  logic [SEL_W-1:0] head;
  logic [N-1:0]     pend_eff;
  logic             push, fwd_pop, rej_pop, pop;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign ready_for_snooper   = (s_state == S_GRANT);
  assign ready_for_forwarder = (f_state == F_GRANT);
  assign head     = fifo_q[rd_ptr];
  assign pend_eff = reject_pend | vm_reject;
  assign pop      = fwd_pop | rej_pop;

  // Descending scan so the candidate closest to rr_ptr is the last one kept.
  always_comb begin
    int idx;
    logic [SEL_W-1:0] cand;
    idx         = 0;
    cand        = '0;
    snoop_found = 1'b0;
    snoop_pick  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      cand = SEL_W'(idx);
      if (vm_snoop_ready[cand]) begin
        snoop_found = 1'b1;
        snoop_pick  = cand;
      end
    end
  end

  always_comb begin
    s_next        = s_state;
    snoop_grant_d = vm_snoop_grant;
    snoop_idx_d   = snoop_idx;
    rr_d          = rr_ptr;
    push          = 1'b0;
    unique case (s_state)
      S_IDLE: begin
        if (snoop_found && order_count < FULL) begin
          s_next        = S_GRANT;
          snoop_grant_d = ONE << snoop_pick;
          snoop_idx_d   = snoop_pick;
        end
      end
      S_GRANT: begin
        if (snooper_done) begin
          push          = (order_count != FULL);
          rr_d          = wrap_inc(snoop_idx);
          snoop_grant_d = '0;
          s_next        = S_IDLE;
        end
      end
      default: s_next = S_IDLE;
    endcase
  end

  always_comb begin
    f_next        = f_state;
    fwd_grant_d   = vm_fwd_grant;
    fwd_sel_d     = fwd_sel;
    fwd_pop       = 1'b0;
    rej_pop       = 1'b0;
    reject_pend_d = pend_eff;
    unique case (f_state)
      F_IDLE: begin
        if (order_count != '0) begin
          if (pend_eff[head]) begin
            rej_pop       = 1'b1;
            reject_pend_d = pend_eff & ~(ONE << head);
          end else if (vm_fwd_ready[head]) begin
            f_next      = F_GRANT;
            fwd_grant_d = ONE << head;
            fwd_sel_d   = head;
          end
        end
      end
      F_GRANT: begin
        if (forwarder_done) begin
          fwd_pop     = 1'b1;
          fwd_grant_d = '0;
          fwd_sel_d   = '0;
          f_next      = F_IDLE;
        end
      end
      default: f_next = F_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      s_state        <= S_IDLE;
      f_state        <= F_IDLE;
      vm_snoop_grant <= '0;
      vm_fwd_grant   <= '0;
      fwd_sel        <= '0;
      snoop_idx      <= '0;
      rr_ptr         <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      order_count    <= '0;
      reject_pend    <= '0;
    end else begin
      s_state        <= s_next;
      f_state        <= f_next;
      vm_snoop_grant <= snoop_grant_d;
      vm_fwd_grant   <= fwd_grant_d;
      fwd_sel        <= fwd_sel_d;
      snoop_idx      <= snoop_idx_d;
      rr_ptr         <= rr_d;
      reject_pend    <= reject_pend_d;
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      if (push && !pop)      order_count <= order_count + 1'b1;
      else if (pop && !push) order_count <= order_count - 1'b1;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (push) fifo_q[wr_ptr] <= snoop_idx;
  end

endmodule

// File: tb/tb_packet_order_scheduler.sv
// Directed bench for packet_order_scheduler with N=4.
// Expected values are hand-derived per edge.
module tb_packet_order_scheduler;

  localparam int N     = 4;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             snooper_done;
  logic             ready_for_snooper;
  logic [N-1:0]     vm_snoop_ready;
  logic [N-1:0]     vm_snoop_grant;
  logic             forwarder_done;
  logic             ready_for_forwarder;
  logic [N-1:0]     vm_fwd_ready;
  logic [N-1:0]     vm_reject;
  logic [N-1:0]     vm_fwd_grant;
  logic [SEL_W-1:0] fwd_sel;
  logic [SEL_W:0]   order_count;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  packet_order_scheduler #(.N(N), .SEL_W(SEL_W)) dut (
    .axi_aclk            (clk),
    .rst                 (rst),
    .snooper_done        (snooper_done),
    .ready_for_snooper   (ready_for_snooper),
    .vm_snoop_ready      (vm_snoop_ready),
    .vm_snoop_grant      (vm_snoop_grant),
    .forwarder_done      (forwarder_done),
    .ready_for_forwarder (ready_for_forwarder),
    .vm_fwd_ready        (vm_fwd_ready),
    .vm_reject           (vm_reject),
    .vm_fwd_grant        (vm_fwd_grant),
    .fwd_sel             (fwd_sel),
    .order_count         (order_count)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sg"},  int'(vm_snoop_grant), 0);
    chk({tag, "_fg"},  int'(vm_fwd_grant), 0);
    chk({tag, "_rs"},  int'(ready_for_snooper), 0);
    chk({tag, "_rf"},  int'(ready_for_forwarder), 0);
    chk({tag, "_sel"}, int'(fwd_sel), 0);
    chk({tag, "_cnt"}, int'(order_count), 0);
  endtask

  initial begin
    rst            = 1'b1;
    snooper_done   = 1'b0;
    forwarder_done = 1'b0;
    vm_snoop_ready = '0;
    vm_fwd_ready   = '0;
    vm_reject      = '0;
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;

    // Four snoops, all VMs ready: grants 0,1,2,3 then stall at full.
    vm_snoop_ready = 4'hF;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sg%0d", i), int'(vm_snoop_grant), 1 << i);
      chk($sformatf("rs%0d", i), int'(ready_for_snooper), 1);
      snooper_done = 1'b1;
      tick();
      snooper_done = 1'b0;
      chk($sformatf("gap%0d", i), int'(vm_snoop_grant), 0);
      chk($sformatf("cnt%0d", i), int'(order_count), i + 1);
      tick();
      if (i < 3) chk($sformatf("sgn%0d", i), int'(vm_snoop_grant), 2 << i);
      else       chk("full_nogrant", int'(vm_snoop_grant), 0);
    end
    tick();
    chk("full_nogrant2", int'(vm_snoop_grant), 0);
    vm_snoop_ready = '0;

    // Forward-ready arrives 2,0,3,1; grants must still go 0,1,2,3.
    vm_fwd_ready = 4'b0100;
    tick();
    chk("f_nohead", int'(vm_fwd_grant), 0);
    vm_fwd_ready = 4'b0101;
    tick();
    chk("fg0", int'(vm_fwd_grant), 4'b0001);
    chk("fs0", int'(fwd_sel), 0);
    chk("rf0", int'(ready_for_forwarder), 1);
    forwarder_done = 1'b1;
    vm_fwd_ready   = 4'b0100;
    tick();
    forwarder_done = 1'b0;
    chk("fc0", int'(order_count), 3);
    chk("fd0", int'(vm_fwd_grant), 0);
    vm_fwd_ready = 4'b1100;
    tick();
    chk("f_stall1", int'(vm_fwd_grant), 0);
    vm_fwd_ready = 4'b1110;
    tick();
    chk("fg1", int'(vm_fwd_grant), 4'b0010);
    chk("fs1", int'(fwd_sel), 1);
    forwarder_done = 1'b1;
    vm_fwd_ready   = 4'b1100;
    tick();
    forwarder_done = 1'b0;
    chk("fc1", int'(order_count), 2);
    tick();
    chk("fg2", int'(vm_fwd_grant), 4'b0100);
    chk("fs2", int'(fwd_sel), 2);
    forwarder_done = 1'b1;
    vm_fwd_ready   = 4'b1000;
    tick();
    forwarder_done = 1'b0;
    chk("fc2", int'(order_count), 1);
    tick();
    chk("fg3", int'(vm_fwd_grant), 4'b1000);
    chk("fs3", int'(fwd_sel), 3);
    forwarder_done = 1'b1;
    vm_fwd_ready   = '0;
    tick();
    forwarder_done = 1'b0;
    chk("fc3", int'(order_count), 0);
    chk("fsel_idle", int'(fwd_sel), 0);
    chk("rf_idle", int'(ready_for_forwarder), 0);

    // Snoop VMs 1 then 2, reject 1 at head, forward 2.
    vm_snoop_ready = 4'b0010;
    tick();
    chk("rj_sg1", int'(vm_snoop_grant), 4'b0010);
    snooper_done = 1'b1;
    tick();
    snooper_done   = 1'b0;
    vm_snoop_ready = 4'b0100;
    tick();
    chk("rj_sg2", int'(vm_snoop_grant), 4'b0100);
    snooper_done = 1'b1;
    tick();
    snooper_done   = 1'b0;
    vm_snoop_ready = '0;
    chk("rj_cnt2", int'(order_count), 2);
    vm_reject = 4'b0010;
    tick();
    vm_reject = '0;
    chk("rj_pop", int'(order_count), 1);
    chk("rj_nofg", int'(vm_fwd_grant), 0);
    vm_fwd_ready = 4'b0100;
    tick();
    chk("rj_fg2", int'(vm_fwd_grant), 4'b0100);
    chk("rj_fs2", int'(fwd_sel), 2);
    forwarder_done = 1'b1;
    vm_fwd_ready   = '0;
    tick();
    forwarder_done = 1'b0;
    chk("rj_cnt0", int'(order_count), 0);

    // rr_ptr=3: snoop VM 0, then only VM 3 ready with rr_ptr=1.
    vm_snoop_ready = 4'b0001;
    tick();
    chk("rr_sg0", int'(vm_snoop_grant), 4'b0001);
    snooper_done = 1'b1;
    tick();
    snooper_done   = 1'b0;
    vm_snoop_ready = 4'b1000;
    tick();
    chk("rr_sg3", int'(vm_snoop_grant), 4'b1000);
    chk("rr_cnt1", int'(order_count), 1);
    // Push of VM 3 and reject-pop of head VM 0 on the same edge.
    snooper_done = 1'b1;
    vm_reject    = 4'b0001;
    tick();
    snooper_done = 1'b0;
    vm_reject    = '0;
    chk("mix_cnt", int'(order_count), 1);
    chk("mix_nofg", int'(vm_fwd_grant), 0);
    vm_fwd_ready   = 4'b1000;
    vm_snoop_ready = 4'b1001;
    tick();
    chk("mix_fg3", int'(vm_fwd_grant), 4'b1000);
    chk("mix_fs3", int'(fwd_sel), 3);
    chk("wrap_sg0", int'(vm_snoop_grant), 4'b0001);

    // Reset while both sides are mid-packet.
    rst = 1'b1;
    tick();
    rst          = 1'b0;
    vm_fwd_ready = '0;
    chk_idle("midrst");
    tick();
    chk("post_rst_sg0", int'(vm_snoop_grant), 4'b0001);
    chk("post_rst_rs", int'(ready_for_snooper), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_order_scheduler.md
Name: packet_order_scheduler

Overview:
- Replaces first-ready arbitration between the snooper, the N parallel BPF VMs and the forwarder with round-robin snoop dispatch and in-order forwarding.
- Each VM index is recorded in an order FIFO when its packet is fully snooped.
- The forwarder is granted only to the VM at the FIFO head, so accepted packets leave in arrival order; rejected packets are retired silently.
- Sits between the snooper/forwarder ports and the per-VM enable gating; its grants also drive the forwarder read-data/length mux selects.

Parameters:
N, 5, number of VMs (>=2)
SEL_W, 3, width of a VM index; must be >= clog2(N)

Ports:
axi_aclk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
snooper_done  in  1  1-cycle pulse, end of snooped packet
ready_for_snooper  out  1  a VM is granted to the snooper
vm_snoop_ready  in  N  per-VM ready_for_snooper
vm_snoop_grant  out  N  one-hot (or zero) snoop enable, registered
forwarder_done  in  1  1-cycle pulse, end of forwarded packet
ready_for_forwarder  out  1  FIFO-head VM is granted to the forwarder
vm_fwd_ready  in  N  per-VM ready_for_forwarder (filter accepted)
vm_reject  in  N  per-VM 1-cycle pulse, filter rejected packet
vm_fwd_grant  out  N  one-hot (or zero) forwarder enable, registered
fwd_sel  out  SEL_W  index of the granted forwarder VM, for the data/len mux; 0 when idle
order_count  out  SEL_W+1  FIFO occupancy, 0..N

Behaviour:
- Reset: all grants 0; ready_for_snooper=0; ready_for_forwarder=0; fwd_sel=0; order_count=0; FIFO pointers 0; reject_pend=0; rr_ptr=0. The same clear applies on any edge with rst high, including mid-packet; in-flight packets are abandoned.
- Order FIFO: depth N, entries SEL_W bits, circular read/write pointers that wrap at N.
  - Push and pop in the same cycle is legal; count is unchanged.
  - Push when full is suppressed. Pop when empty cannot occur.
- Snoop side, states S_IDLE / S_GRANT:
  - S_IDLE: when count<N, select the first VM with vm_snoop_ready=1, searching from rr_ptr upward with wrap-around.
  - On selection, the next edge registers the one-hot grant and enters S_GRANT. ready_for_snooper=1 exactly while in S_GRANT.
  - S_GRANT: on the edge sampling snooper_done=1:
    - push the granted index;
    - rr_ptr <= granted index+1 (wrap at N);
    - grant <= 0;
    - return to S_IDLE.
  - After any done there is a guaranteed 1-cycle gap with no grant; the earliest new grant is 2 edges after done.
  - The grant is held regardless of vm_snoop_ready changes while in S_GRANT. snooper_done in S_IDLE is ignored.
- Reject tracking:
  - vm_reject[i]=1 sets reject_pend[i].
  - When the FIFO head index h has reject_pend[h]=1 and forward side is F_IDLE: pop and clear reject_pend[h] in one edge, with no grant issued.
  - A reject and a head-pop for the same VM in the same cycle combine: the entry pops immediately.
- Forward side, states F_IDLE / F_GRANT:
  - F_IDLE: when the FIFO is non-empty, h=head, reject_pend[h]=0 and vm_fwd_ready[h]=1, the next edge sets vm_fwd_grant=onehot(h), fwd_sel=h, ready_for_forwarder=1, and enters F_GRANT.
  - vm_fwd_ready of non-head VMs is ignored, so out-of-order completion stalls until the head completes.
  - F_GRANT: on the edge sampling forwarder_done=1: pop the FIFO, grant<=0, fwd_sel<=0, return to F_IDLE. forwarder_done in F_IDLE is ignored.
- Latency: the forwarder grant appears 1 edge after the head's vm_fwd_ready rises. A reject pop takes 1 edge after both the reject is registered and the VM is at head.
- Snoop and forward sides run concurrently. The same VM index may be granted to both at once only if the VM itself reports both ready.

Test Plan:
- N=4, all vm_snoop_ready=1; issue four snoop packets → grants in order 0,1,2,3; each grant rises 2 edges after the previous done; order_count steps 1,2,3,4; no fifth grant while count=4.
- Continuing: vm_fwd_ready raised in order 2,0,3,1 → forwarder grants strictly 0,1,2,3; fwd_sel matches each; order_count decrements on each forwarder_done.
- Snoop VMs 1 then 2; pulse vm_reject[1] → head 1 pops without any vm_fwd_grant; vm_fwd_ready[2]=1 → grant onehot(2) on the next edge.
- With VM at head in F_IDLE: assert snooper_done for a new packet and vm_reject[head] in the same cycle → order_count unchanged; FIFO holds the new index.
- Only vm_snoop_ready[3]=1 with rr_ptr=1 → grant VM 3; then VMs 0 and 3 ready → grant VM 0 (wrap).
- Assert rst for 1 cycle mid-snoop and mid-forward → on the next edge all grants, readies, fwd_sel and order_count are 0; a subsequent packet is granted to VM 0.
